// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and its counter.
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t USR_HOLD = 2'b00;
    localparam usr_mode_t USR_SHR  = 2'b01;
    localparam usr_mode_t USR_SHL  = 2'b10;
    localparam usr_mode_t USR_LOAD = 2'b11;

endpackage

// File: rtl/usr_shift_counter.sv
// Shift counter: pulses done for one cycle on every BITS-th inc; clr restarts the count.
// Latency 1 cycle; no backpressure, inc/clr are taken every edge (clr has priority).
module usr_shift_counter #(
    parameter int BITS  = 4,
    parameter int CNT_W = $clog2(BITS)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_W'(BITS - 1)) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register (hold/shr/shl/load), 1-cycle latency, never stalls.
// Rotate via ROT is built only when USR_ROTATE_EN is defined.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      MODE,
    input  logic            SI_R,
    input  logic            SI_L,
    input  logic            ROT,
    input  logic [BITS-1:0] PI,
    output logic [BITS-1:0] PO,
    output logic            SO_R,
    output logic            SO_L,
    output logic            DONE
);

    usr_mode_t       mode;
    logic            fill_r;
    logic            fill_l;
    logic [BITS-1:0] po_nxt;

    assign mode = usr_mode_t'(MODE);

`ifdef USR_ROTATE_EN
    assign fill_r = ROT ? PO[0]      : SI_R;
    assign fill_l = ROT ? PO[BITS-1] : SI_L;
`else
    logic unused_rot;
    assign unused_rot = ROT;
    assign fill_r     = SI_R;
    assign fill_l     = SI_L;
`endif

    always_comb begin
        po_nxt = PO;
        case (mode)
            USR_SHR:  po_nxt = {fill_r, PO[BITS-1:1]};
            USR_SHL:  po_nxt = {PO[BITS-2:0], fill_l};
            USR_LOAD: po_nxt = PI;
            default:  po_nxt = PO;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PO <= '0;
        end else begin
            PO <= po_nxt;
        end
    end

    assign SO_R = PO[0];
    assign SO_L = PO[BITS-1];

    // Direction changes keep counting; only a load restarts the count.
    usr_shift_counter #(
        .BITS (BITS)
    ) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (mode == USR_LOAD),
        .inc  ((mode == USR_SHR) || (mode == USR_SHL)),
        .done (DONE)
    );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (BITS=4); expectations are hand-computed per edge.
module tb_universal_shift_reg;

    localparam int BITS = 4;

    logic            CLK;
    logic            RST;
    logic [1:0]      MODE;
    logic            SI_R;
    logic            SI_L;
    logic            ROT;
    logic [BITS-1:0] PI;
    logic [BITS-1:0] PO;
    logic            SO_R;
    logic            SO_L;
    logic            DONE;

    typedef struct packed {
        logic [BITS-1:0] po;
        logic            done;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    universal_shift_reg #(.BITS(BITS)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .MODE (MODE),
        .SI_R (SI_R),
        .SI_L (SI_L),
        .ROT  (ROT),
        .PI   (PI),
        .PO   (PO),
        .SO_R (SO_R),
        .SO_L (SO_L),
        .DONE (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [BITS-1:0] epo, input logic edone);
        n_vec++;
        if (PO !== epo || DONE !== edone || SO_R !== epo[0] || SO_L !== epo[BITS-1]) begin
            n_fail++;
            $display("FAIL %s: got po=%h so_r=%b so_l=%b done=%b, required po=%h so_r=%b so_l=%b done=%b",
                     name, PO, SO_R, SO_L, DONE, epo, epo[0], epo[BITS-1], edone);
        end
    endtask

    // Monitor: one expected entry is consumed after each edge that has one queued.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, e.po, e.done);
            end
        end
    end

    // Drive one vector before the next rising edge and queue what that edge must produce.
    task automatic step(input string name, input logic [1:0] m, input logic sr, input logic sl,
                        input logic rot, input logic [BITS-1:0] pi,
                        input logic [BITS-1:0] epo, input logic edone);
        exp_t e;
        MODE = m;
        SI_R = sr;
        SI_L = sl;
        ROT  = rot;
        PI   = pi;
        e.po   = epo;
        e.done = edone;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge CLK);
    endtask

    initial begin
        RST  = 1'b0;
        MODE = 2'b00;
        SI_R = 1'b0;
        SI_L = 1'b0;
        ROT  = 1'b0;
        PI   = '0;

        // Reset held over 3 edges with a load pending
        step("rst_hold0", 2'b11, 0, 0, 0, 4'hF, 4'h0, 0);
        step("rst_hold1", 2'b11, 0, 0, 0, 4'hF, 4'h0, 0);
        step("rst_hold2", 2'b11, 0, 0, 0, 4'hF, 4'h0, 0);
        RST = 1'b1;
        step("rst_rel_load", 2'b11, 0, 0, 0, 4'hF, 4'hF, 0);

        // Right shift of ones into zero
        step("shr_load0", 2'b11, 0, 0, 0, 4'h0, 4'h0, 0);
        step("shr_1", 2'b01, 1, 0, 0, 4'h0, 4'h8, 0);
        step("shr_2", 2'b01, 1, 0, 0, 4'h0, 4'hC, 0);
        step("shr_3", 2'b01, 1, 0, 0, 4'h0, 4'hE, 0);
        step("shr_4_done", 2'b01, 1, 0, 0, 4'h0, 4'hF, 1);

        // Load directly after DONE, then mixed directions
        step("mix_load9", 2'b11, 0, 0, 0, 4'h9, 4'h9, 0);
        step("mix_shl1", 2'b10, 0, 0, 0, 4'h0, 4'h2, 0);
        step("mix_shl2", 2'b10, 0, 0, 0, 4'h0, 4'h4, 0);
        step("mix_shr3", 2'b01, 1, 0, 0, 4'h0, 4'hA, 0);
        step("mix_shr4_done", 2'b01, 1, 0, 0, 4'h0, 4'hD, 1);
        step("mix_hold", 2'b00, 1, 1, 0, 4'h0, 4'hD, 0);

        // Hold mid-count, then load clears the count
        step("hl_load5", 2'b11, 0, 0, 0, 4'h5, 4'h5, 0);
        step("hl_shr1", 2'b01, 0, 0, 0, 4'h0, 4'h2, 0);
        step("hl_shr2", 2'b01, 0, 0, 0, 4'h0, 4'h1, 0);
        for (int i = 0; i < 5; i++)
            step("hl_hold", 2'b00, 1, 1, 0, 4'hE, 4'h1, 0);
        step("hl_load3", 2'b11, 0, 0, 0, 4'h3, 4'h3, 0);
        step("hl_shr_a", 2'b01, 0, 0, 0, 4'h0, 4'h1, 0);
        step("hl_shr_b", 2'b01, 0, 0, 0, 4'h0, 4'h0, 0);
        step("hl_shr_c", 2'b01, 0, 0, 0, 4'h0, 4'h0, 0);
        step("hl_shr_d_done", 2'b01, 0, 0, 0, 4'h0, 4'h0, 1);

        // Async reset between edges after 2 shifts
        step("ar_load6", 2'b11, 0, 0, 0, 4'h6, 4'h6, 0);
        step("ar_shr1", 2'b01, 0, 0, 0, 4'h0, 4'h3, 0);
        step("ar_shr2", 2'b01, 0, 0, 0, 4'h0, 4'h1, 0);
        #2;
        RST = 1'b0;
        #1;
        check("ar_immediate", 4'h0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        step("ar_shr_a", 2'b01, 1, 0, 0, 4'h0, 4'h8, 0);
        step("ar_shr_b", 2'b01, 1, 0, 0, 4'h0, 4'hC, 0);
        step("ar_shr_c", 2'b01, 1, 0, 0, 4'h0, 4'hE, 0);
        step("ar_shr_d_done", 2'b01, 1, 0, 0, 4'h0, 4'hF, 1);

        // Rotate select: recirculates only when the rotate build is enabled
        step("rot_load9", 2'b11, 0, 0, 0, 4'h9, 4'h9, 0);
`ifdef USR_ROTATE_EN
        step("rot_1", 2'b01, 0, 0, 1, 4'h0, 4'hC, 0);
        step("rot_2", 2'b01, 0, 0, 1, 4'h0, 4'h6, 0);
        step("rot_3", 2'b01, 0, 0, 1, 4'h0, 4'h3, 0);
        step("rot_4_done", 2'b01, 0, 0, 1, 4'h0, 4'h9, 1);
        step("rotl_1", 2'b10, 0, 0, 1, 4'h0, 4'h3, 0);
`else
        step("rot_1", 2'b01, 0, 0, 1, 4'h0, 4'h4, 0);
        step("rot_2", 2'b01, 0, 0, 1, 4'h0, 4'h2, 0);
        step("rot_3", 2'b01, 0, 0, 1, 4'h0, 4'h1, 0);
        step("rot_4_done", 2'b01, 0, 0, 1, 4'h0, 4'h0, 1);
        step("rotl_1", 2'b10, 0, 1, 1, 4'h0, 4'h1, 0);
`endif
        step("end_hold", 2'b00, 0, 0, 0, 4'h0,
`ifdef USR_ROTATE_EN
             4'h3,
`else
             4'h1,
`endif
             0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
